bp_cce_cfg_link_arbiter: RTL and testbench



---
 rtl/bp_cce_cfg_link_arbiter.sv | 166 ++++++++++++++++
 tb/tb_bp_cce_cfg_link_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_cce_cfg_link_arbiter.sv
// Round-robin arbiter sharing one CCE config-link target among several masters,
// with burst lock, single outstanding read tracking and a read timeout.
module bp_cce_cfg_link_arbiter #(
    parameter int unsigned num_req_p             = 2,
    parameter int unsigned cfg_link_addr_width_p = 16,
    parameter int unsigned cfg_link_data_width_p = 32,
    parameter int unsigned read_timeout_p        = 255
) (
    input  logic                                             clk_i,
    input  logic                                             reset_i,
    input  logic [num_req_p-1:0][cfg_link_addr_width_p-2:0]  req_addr_i,
    input  logic [num_req_p-1:0][cfg_link_data_width_p-1:0]  req_data_i,
    input  logic [num_req_p-1:0]                             req_v_i,
    input  logic [num_req_p-1:0]                             req_w_i,
    input  logic [num_req_p-1:0]                             req_lock_i,
    output logic [num_req_p-1:0]                             req_ready_o,
    output logic [num_req_p-1:0][cfg_link_data_width_p-1:0]  resp_data_o,
    output logic [num_req_p-1:0]                             resp_v_o,
    input  logic [num_req_p-1:0]                             resp_ready_i,
    output logic [cfg_link_addr_width_p-2:0]                 config_addr_o,
    output logic [cfg_link_data_width_p-1:0]                 config_data_o,
    output logic                                             config_v_o,
    output logic                                             config_w_o,
    input  logic                                             config_ready_i,
    input  logic [cfg_link_data_width_p-1:0]                 config_data_i,
    input  logic                                             config_v_i,
    output logic                                             config_ready_o,
    output logic                                             timeout_o
);

    localparam int unsigned dw_lp = cfg_link_data_width_p;
    localparam int unsigned ow_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int unsigned cw_lp = $clog2(read_timeout_p + 1);

    typedef enum logic [1:0] {
        e_idle  = 2'd0,
        e_grant = 2'd1,
        e_wait  = 2'd2,
        e_resp  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [ow_lp-1:0]   owner_q, owner_d;
    logic [ow_lp-1:0]   last_q, last_d;
    logic [cw_lp-1:0]   cnt_q, cnt_d;
    logic [dw_lp-1:0]   buf_q, buf_d;
    logic               timeout_q, timeout_d;

    // First requester searching upward from last+1 with wrap.
    function automatic logic [ow_lp-1:0] rr_pick(input logic [num_req_p-1:0] v,
                                                 input logic [ow_lp-1:0]     last);
        logic [ow_lp-1:0] pick;
        logic             found;
        int unsigned      cand;
        pick  = last;
        found = 1'b0;
        for (int unsigned i = 1; i <= num_req_p; i++) begin
            cand = 32'(last) + i;
            if (cand >= num_req_p) cand = cand - num_req_p;
            if (!found && v[ow_lp'(cand)]) begin
                found = 1'b1;
                pick  = ow_lp'(cand);
            end
        end
        return pick;
    endfunction

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= e_idle;
            owner_q   <= '0;
            last_q    <= ow_lp'(num_req_p - 1);
            cnt_q     <= '0;
            buf_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            buf_q     <= buf_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        timeout_d = timeout_q;
        case (state_q)
            e_idle: begin
                if (|req_v_i) begin
                    owner_d = rr_pick(req_v_i, last_q);
                    last_d  = owner_d;
                    state_d = e_grant;
                end
            end
            e_grant: begin
                if (req_v_i[owner_q] && config_ready_i) begin
                    if (req_w_i[owner_q]) begin
                        state_d = req_lock_i[owner_q] ? e_grant : e_idle;
                    end else begin
                        state_d = e_wait;
                        cnt_d   = '0;
                    end
                end else if (!req_v_i[owner_q]) begin
                    state_d = req_lock_i[owner_q] ? e_grant : e_idle;
                end
            end
            e_wait: begin
                // Real data takes priority over a coincident timeout.
                if (config_v_i) begin
                    buf_d   = config_data_i;
                    state_d = e_resp;
                end else if (cnt_q == cw_lp'(read_timeout_p - 1)) begin
                    buf_d     = '1;
                    timeout_d = 1'b1;
                    state_d   = e_resp;
                end else begin
                    cnt_d = cnt_q + cw_lp'(1);
                end
            end
            e_resp: begin
                if (resp_ready_i[owner_q]) begin
                    state_d = req_lock_i[owner_q] ? e_grant : e_idle;
                end
            end
            default: state_d = e_idle;
        endcase
    end

    always_comb begin
        req_ready_o    = '0;
        resp_v_o       = '0;
        resp_data_o    = '0;
        config_v_o     = 1'b0;
        config_w_o     = 1'b0;
        config_addr_o  = '0;
        config_data_o  = '0;
        config_ready_o = 1'b0;
        case (state_q)
            e_grant: begin
                config_v_o           = req_v_i[owner_q];
                config_w_o           = req_w_i[owner_q];
                config_addr_o        = req_addr_i[owner_q];
                config_data_o        = req_data_i[owner_q];
                req_ready_o[owner_q] = config_ready_i;
            end
            e_wait: config_ready_o = 1'b1;
            e_resp: begin
                resp_v_o[owner_q]    = 1'b1;
                resp_data_o[owner_q] = buf_q;
            end
            default: ;
        endcase
    end

    assign timeout_o = timeout_q;

    config_v_only_in_wait_a: assert property (@(posedge clk_i) disable iff (reset_i)
        config_v_i |-> (state_q == e_wait));

endmodule

// File: tb/tb_bp_cce_cfg_link_arbiter.sv
// Scoreboard bench for bp_cce_cfg_link_arbiter: master drivers, a target model
// and a monitor that checks target transfers and routed responses.
module tb_bp_cce_cfg_link_arbiter;

    localparam int unsigned NR    = 2;
    localparam int unsigned AW    = 15;
    localparam int unsigned DW    = 32;
    localparam int unsigned TO    = 8;
    localparam int          BOUND = 300;

    typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; logic w; } tx_t;
    typedef struct packed { logic [DW-1:0] d; logic dead; } rs_t;

    logic                   clk_i = 1'b0;
    logic                   reset_i;
    logic [NR-1:0][AW-1:0]  req_addr_i;
    logic [NR-1:0][DW-1:0]  req_data_i;
    logic [NR-1:0]          req_v_i, req_w_i, req_lock_i, req_ready_o;
    logic [NR-1:0][DW-1:0]  resp_data_o;
    logic [NR-1:0]          resp_v_o, resp_ready_i;
    logic [AW-1:0]          config_addr_o;
    logic [DW-1:0]          config_data_o, config_data_i;
    logic                   config_v_o, config_w_o, config_ready_i;
    logic                   config_v_i, config_ready_o, timeout_o;

    bp_cce_cfg_link_arbiter #(
        .num_req_p(NR), .cfg_link_addr_width_p(AW + 1),
        .cfg_link_data_width_p(DW), .read_timeout_p(TO)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_v_i(req_v_i),
        .req_w_i(req_w_i), .req_lock_i(req_lock_i), .req_ready_o(req_ready_o),
        .resp_data_o(resp_data_o), .resp_v_o(resp_v_o), .resp_ready_i(resp_ready_i),
        .config_addr_o(config_addr_o), .config_data_o(config_data_o),
        .config_v_o(config_v_o), .config_w_o(config_w_o), .config_ready_i(config_ready_i),
        .config_data_i(config_data_i), .config_v_i(config_v_i),
        .config_ready_o(config_ready_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int  total = 0;
    int  bad   = 0;
    tx_t exp_tgt[NR][$];
    rs_t exp_resp[NR][$];
    int  grant_log[$];
    bit  exp_sticky = 1'b0;

    bit            tgt_rdy_rand = 1'b0, tgt_dead = 1'b0, resp_rdy_rand = 1'b0;
    bit            tgt_data_use = 1'b0, tgt_pend = 1'b0, tgt_consumed = 1'b0;
    int            tgt_delay_fix = -1, tgt_pm = 0, tgt_cnt = 0;
    logic [DW-1:0] tgt_data_fix = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_evt(input string nm);
        total++;
        bad++;
        $display("FAIL %s: event occurred but was not expected", nm);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Master driver: present one request and hold it until accepted.
    task automatic issue(input int m, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic w, input logic lk);
        tx_t t;
        int  n;
        bit  done;
        t.a = a; t.d = d; t.w = w;
        req_addr_i[m] = a; req_data_i[m] = d; req_w_i[m] = w;
        req_lock_i[m] = lk; req_v_i[m] = 1'b1;
        exp_tgt[m].push_back(t);
        n = 0; done = 1'b0;
        while (!done && n < BOUND) begin
            @(negedge clk_i);
            if (req_ready_o[m]) done = 1'b1;
            n++;
        end
        step();
        req_v_i[m] = 1'b0;
        if (!done) fail_evt($sformatf("issue_timeout_m%0d", m));
    endtask

    task automatic monitor();
        int  m;
        tx_t t;
        rs_t r;
        if (config_v_o && config_ready_i) begin
            chk("grant_onehot", 64'($countones(req_ready_o)), 64'd1);
            m = -1;
            for (int i = 0; i < NR; i++) if (req_ready_o[i]) m = i;
            if (m >= 0) begin
                grant_log.push_back(m);
                if (exp_tgt[m].size() == 0) fail_evt("tgt_unexpected");
                else begin
                    t = exp_tgt[m].pop_front();
                    chk("tgt_addr", 64'(config_addr_o), 64'(t.a));
                    chk("tgt_data", 64'(config_data_o), 64'(t.d));
                    chk("tgt_w", 64'(config_w_o), 64'(t.w));
                    if (!config_w_o) begin
                        tgt_pend = 1'b1;
                        tgt_pm   = m;
                        tgt_cnt  = (tgt_delay_fix >= 0) ? tgt_delay_fix : int'($urandom_range(0, 7));
                    end
                end
            end
        end
        if (config_v_i && config_ready_o) tgt_consumed = 1'b1;
        for (int i = 0; i < NR; i++) begin
            if (resp_v_o[i] && resp_ready_i[i]) begin
                if (exp_resp[i].size() == 0) fail_evt("resp_unexpected");
                else begin
                    r = exp_resp[i].pop_front();
                    chk("resp_data", 64'(resp_data_o[i]), 64'(r.d));
                    chk("timeout_flag", 64'(timeout_o), r.dead ? 64'd1 : 64'(exp_sticky));
                    if (r.dead) exp_sticky = 1'b1;
                end
            end
        end
        if (|resp_v_o) begin
            chk("resp_v_onehot", 64'($countones(resp_v_o)), 64'd1);
            for (int i = 0; i < NR; i++)
                if (!resp_v_o[i]) chk("resp_nonowner_zero", 64'(resp_data_o[i]), 64'd0);
        end
    endtask

    // Target model: responds to accepted reads after a delay (or never when dead).
    task automatic drive_target();
        rs_t r;
        config_ready_i = tgt_rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (tgt_consumed) begin
            config_v_i = 1'b0; config_data_i = '0; tgt_consumed = 1'b0;
        end
        if (tgt_pend) begin
            if (tgt_dead) begin
                r.d = '1; r.dead = 1'b1;
                exp_resp[tgt_pm].push_back(r);
                tgt_pend = 1'b0;
            end else if (tgt_cnt == 0) begin
                r.d = tgt_data_use ? tgt_data_fix : DW'($urandom);
                r.dead = 1'b0;
                config_v_i = 1'b1; config_data_i = r.d;
                exp_resp[tgt_pm].push_back(r);
                tgt_pend = 1'b0;
            end else tgt_cnt--;
        end
        if (resp_rdy_rand) resp_ready_i = NR'($urandom_range(0, 3));
    endtask

    initial begin
        forever begin
            @(negedge clk_i);
            if (!reset_i) monitor();
            @(posedge clk_i);
            #1;
            if (!reset_i) drive_target();
        end
    end

    task automatic wait_drain();
        int n = 0;
        while ((exp_resp[0].size() + exp_resp[1].size() + int'(tgt_pend)) != 0 && n < BOUND) begin
            step();
            n++;
        end
        if (n >= BOUND) fail_evt("drain_timeout");
        chk("tgt_queue_empty", 64'(exp_tgt[0].size() + exp_tgt[1].size()), 64'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctrl"}, 64'({config_v_o, config_w_o, config_ready_o, req_ready_o,
                                 resp_v_o, timeout_o}), 64'd0);
        chk({tag, "_cfg_bus"}, 64'({config_addr_o, config_data_o}), 64'd0);
        chk({tag, "_resp_data"}, 64'(resp_data_o), 64'd0);
    endtask

    task automatic wait_resp(input int m, output int n);
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!resp_v_o[m] && n < BOUND);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, c0;
        reset_i = 1'b1;
        req_addr_i = '0; req_data_i = '0; req_v_i = '0; req_w_i = '0; req_lock_i = '0;
        resp_ready_i = '0; config_ready_i = 1'b0; config_data_i = '0; config_v_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_zero("reset");
        step();
        reset_i = 1'b0;
        resp_ready_i = '1;

        // Single write: one IDLE cycle before the target sees it.
        fork
            issue(0, 15'h0004, 32'h1234_5678, 1'b1, 1'b0);
            begin
                @(negedge clk_i); chk("lat_idle_v", 64'(config_v_o), 64'd0);
                @(negedge clk_i); chk("lat_grant_v", 64'(config_v_o), 64'd1);
                chk("lat_ready", 64'(req_ready_o), 64'd1);
            end
        join
        @(negedge clk_i);
        chk("wr_back_idle", 64'({config_v_o, config_ready_o, resp_v_o}), 64'd0);
        wait_drain();

        // Both masters writing continuously without lock.
        grant_log.delete();
        fork
            for (int i = 0; i < 4; i++) issue(0, AW'($urandom), DW'($urandom), 1'b1, 1'b0);
            for (int i = 0; i < 4; i++) issue(1, AW'($urandom), DW'($urandom), 1'b1, 1'b0);
        join
        wait_drain();
        chk("alt_len", 64'(grant_log.size()), 64'd8);
        c0 = 0;
        foreach (grant_log[i]) if (grant_log[i] == 0) c0++;
        chk("alt_half", 64'(c0), 64'd4);
        for (int i = 1; i < grant_log.size(); i++)
            chk("alt_order", 64'(grant_log[i] != grant_log[i-1]), 64'd1);

        // Master 1 read, response held by a slow consumer.
        resp_ready_i = '0;
        tgt_delay_fix = 3; tgt_data_use = 1'b1; tgt_data_fix = 32'hDEAD_BEEF;
        issue(1, 15'h0010, 32'h0, 1'b0, 1'b0);
        wait_resp(1, n);
        chk("rd_latency", 64'(n), 64'd5);
        chk("rd_data_held", 64'(resp_data_o[1]), 64'hDEAD_BEEF);
        chk("rd_other_v", 64'(resp_v_o[0]), 64'd0);
        @(negedge clk_i);
        chk("rd_v_held", 64'(resp_v_o[1]), 64'd1);
        chk("rd_data_held2", 64'(resp_data_o[1]), 64'hDEAD_BEEF);
        step();
        resp_ready_i = '1;
        step();
        @(negedge clk_i);
        chk("rd_consumed", 64'(resp_v_o), 64'd0);
        wait_drain();

        // Response on the last cycle before timeout: data wins.
        tgt_delay_fix = 7; tgt_data_fix = 32'hA5A5_0007;
        issue(0, 15'h0011, 32'h0, 1'b0, 1'b0);
        wait_drain();
        chk("boundary_no_timeout", 64'(timeout_o), 64'd0);

        // Locked burst from master 0 while master 1 waits.
        tgt_delay_fix = -1; tgt_data_use = 1'b0;
        grant_log.delete();
        fork
            for (int i = 0; i < 4; i++) issue(0, AW'(16'h0100 + i), DW'($urandom), 1'b1, i < 3);
            begin step(); issue(1, 15'h0200, 32'hCAFE_0001, 1'b1, 1'b0); end
        join
        wait_drain();
        chk("lock_len", 64'(grant_log.size()), 64'd5);
        if (grant_log.size() >= 5) begin
            for (int i = 0; i < 4; i++) chk("lock_order_m0", 64'(grant_log[i]), 64'd0);
            chk("lock_next_m1", 64'(grant_log[4]), 64'd1);
        end

        // Randomized traffic with random backpressure on both sides.
        tgt_rdy_rand = 1'b1; resp_rdy_rand = 1'b1;
        fork
            for (int i = 0; i < 30; i++) begin
                repeat ($urandom_range(0, 3)) step();
                issue(0, AW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            end
            for (int i = 0; i < 30; i++) begin
                repeat ($urandom_range(0, 3)) step();
                issue(1, AW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            end
        join
        resp_rdy_rand = 1'b0; tgt_rdy_rand = 1'b0;
        step();
        resp_ready_i = '1;
        wait_drain();

        // Dead target: synthesized all-ones response after TO cycles.
        tgt_dead = 1'b1;
        issue(0, 15'h0020, 32'h0, 1'b0, 1'b0);
        wait_resp(0, n);
        chk("to_latency", 64'(n), 64'(TO + 1));
        chk("to_data", 64'(resp_data_o[0]), 64'hFFFF_FFFF);
        chk("to_flag", 64'(timeout_o), 64'd1);
        wait_drain();
        tgt_dead = 1'b0; tgt_delay_fix = 1; tgt_data_use = 1'b1; tgt_data_fix = 32'h0BAD_F00D;
        issue(0, 15'h0021, 32'h0, 1'b0, 1'b0);
        wait_drain();
        chk("to_sticky", 64'(timeout_o), 64'd1);

        // Reset while waiting for a read response.
        tgt_dead = 1'b1;
        issue(0, 15'h0030, 32'h0, 1'b0, 1'b0);
        step(); step();
        reset_i = 1'b1;
        step();
        @(negedge clk_i);
        check_zero("mid_reset");
        exp_resp[0].delete(); exp_resp[1].delete();
        exp_sticky = 1'b0; tgt_pend = 1'b0; tgt_dead = 1'b0;
        step();
        reset_i = 1'b0;
        grant_log.delete();
        fork
            issue(0, 15'h0040, 32'h1111_0000, 1'b1, 1'b0);
            issue(1, 15'h0041, 32'h2222_0000, 1'b1, 1'b0);
        join
        wait_drain();
        chk("post_reset_len", 64'(grant_log.size()), 64'd2);
        if (grant_log.size() > 0) chk("post_reset_first", 64'(grant_log[0]), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
